gb_lcd_pixel_stream: RTL and testbench

Pixel-stream conditioner between the GameBoy PPU pixel pipeline and the GameBoy_VGA LCD framebuffer. It applies the DMG palettes (BGP/OBP0/OBP1) and tracks the 160x144 raster position. It drives LD/PX_VALID so that every frame contains exactly 23040 pixel writes in raster order, because the framebuffer write counter has no resync. Short lines and frames are padded, excess pixels are dropped, and LCD-off is rendered as a full blank (shade 0) frame.

---
 rtl/gb_lcd_pixel_stream.sv | 238 +++++++++++++++++++++++
 tb/tb_gb_lcd_pixel_stream.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_lcd_pixel_stream.sv
// gb_lcd_pixel_stream
//
// Sits between the PPU pixel pipeline and the LCD framebuffer. It applies the DMG
// palettes and tracks the raster position. It guarantees exactly GB_W*GB_H
// writes per frame, in raster order, because the framebuffer write counter
// never resyncs. To do that it pads short lines and early frames with shade 0,
// drops excess pixels, and renders LCD-off as a complete blank frame.
//
// Optional feature macro: GB_LCD_STREAM_PALETTE_EN
//   defined   : LD = selected palette[2*idx+1 : 2*idx]
//   undefined : LD = ppu_px; bgp/obp0/obp1/ppu_px_pal are ignored
//
// Ports
//   GameBoy_clk       2^22 Hz clock; all state changes on its rising edge
//   GameBoy_reset_n   asynchronous active-low reset
//   ppu_px            PPU colour index
//   ppu_px_pal        palette select: 00 BG, 01 OBP0, 10 OBP1, 11 BG
//   ppu_px_valid      one pixel per asserted cycle
//   ppu_line_end      pulse at HBlank entry
//   ppu_frame_start   pulse at LY=0 line start
//   lcd_en            LCDC bit 7 (level)
//   bgp, obp0, obp1   palette registers
//   err_clr           clears the sticky error flags
//   LD, PX_VALID      shade and write strobe to the framebuffer (registered)
//   px_x, px_y        position of the next write
//   frame_done        pulse with the final write of a frame
//   err_short         sticky: padding happened
//   err_long          sticky: a pixel was dropped
module gb_lcd_pixel_stream #(
  parameter int unsigned GB_W = 160,
  parameter int unsigned GB_H = 144
) (
  input  logic       GameBoy_clk,
  input  logic       GameBoy_reset_n,
  input  logic [1:0] ppu_px,
  input  logic [1:0] ppu_px_pal,
  input  logic       ppu_px_valid,
  input  logic       ppu_line_end,
  input  logic       ppu_frame_start,
  input  logic       lcd_en,
  input  logic [7:0] bgp,
  input  logic [7:0] obp0,
  input  logic [7:0] obp1,
  input  logic       err_clr,
  output logic [1:0] LD,
  output logic       PX_VALID,
  output logic [7:0] px_x,
  output logic [7:0] px_y,
  output logic       frame_done,
  output logic       err_short,
  output logic       err_long
);

  localparam logic [7:0] LastX = 8'(GB_W - 1);
  localparam logic [7:0] EndX  = 8'(GB_W);
  localparam logic [7:0] LastY = 8'(GB_H - 1);

  typedef enum logic [2:0] {
    StVblank, StActive, StPadLine, StPadFrame, StOffPad, StOffFill, StOff
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] px_x_q, px_x_d, px_y_q, px_y_d;
  logic [1:0] ld_q, ld_d;
  logic       vld_q, vld_d, done_q, done_d;
  logic       err_short_q, err_long_q, set_short, set_long;
  logic [1:0] shade;

`ifdef GB_LCD_STREAM_PALETTE_EN
  logic [7:0] pal;
  always_comb begin
    case (ppu_px_pal)
      2'b01:   pal = obp0;
      2'b10:   pal = obp1;
      default: pal = bgp;
    endcase
    shade = pal[{ppu_px, 1'b0} +: 2];
  end
`else
  logic unused_pal;
  assign unused_pal = ^{bgp, obp0, obp1, ppu_px_pal};
  assign shade      = ppu_px;
`endif

  logic [7:0] pad_x, pad_y, norm_x, norm_y, line_x;
  logic       frame_last, at_origin, off_state;

  always_comb begin
    state_d   = state_q;
    px_x_d    = px_x_q;
    px_y_d    = px_y_q;
    ld_d      = 2'b00;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    line_x    = px_x_q;

    frame_last = (px_x_q == LastX) && (px_y_q == LastY);
    at_origin  = (px_x_q == 8'd0) && (px_y_q == 8'd0);
    off_state  = state_q inside {StOffPad, StOffFill, StOff};

    // Position after a write at the current position, wrapping through the raster
    if (px_x_q == LastX) begin
      pad_x = 8'd0;
      pad_y = (px_y_q == LastY) ? 8'd0 : px_y_q + 8'd1;
    end else begin
      pad_x = px_x_q + 8'd1;
      pad_y = px_y_q;
    end

    // A full line still waiting for its line_end is stepped past before padding
    if (px_x_q == EndX) begin
      norm_x = 8'd0;
      norm_y = px_y_q + 8'd1;
    end else begin
      norm_x = px_x_q;
      norm_y = px_y_q;
    end

    if (!lcd_en && !off_state) begin
      state_d = StOffPad;
      px_x_d  = norm_x;
      px_y_d  = norm_y;
    end else begin
      unique case (state_q)
        StVblank: begin
          set_long = ppu_px_valid;
          if (ppu_frame_start) begin
            state_d = StActive;
            px_x_d  = 8'd0;
            px_y_d  = 8'd0;
          end
        end
        StActive: begin
          if (ppu_frame_start && !at_origin) begin
            state_d   = StPadFrame;
            px_x_d    = norm_x;
            px_y_d    = norm_y;
            set_short = 1'b1;
            set_long  = ppu_px_valid;
          end else begin
            // A pixel in the line_end cycle belongs to the line being closed
            if (ppu_px_valid) begin
              if (px_x_q == EndX) begin
                set_long = 1'b1;
              end else begin
                vld_d  = 1'b1;
                ld_d   = shade;
                line_x = px_x_q + 8'd1;
              end
            end
            px_x_d = line_x;
            if (vld_d && frame_last) begin
              done_d  = 1'b1;
              state_d = StVblank;
              px_x_d  = 8'd0;
              px_y_d  = 8'd0;
            end else if (ppu_line_end) begin
              if (line_x == EndX) begin
                px_x_d = 8'd0;
                px_y_d = px_y_q + 8'd1;
              end else begin
                state_d   = StPadLine;
                set_short = 1'b1;
              end
            end
          end
        end
        StPadLine: begin
          set_long = ppu_px_valid;
          if (ppu_frame_start && !at_origin) begin
            state_d   = StPadFrame;
            set_short = 1'b1;
          end else begin
            vld_d  = 1'b1;
            px_x_d = pad_x;
            px_y_d = pad_y;
            if (px_x_q == LastX) begin
              done_d  = frame_last;
              state_d = frame_last ? StVblank : StActive;
            end
          end
        end
        StPadFrame, StOffPad, StOffFill: begin
          vld_d  = 1'b1;
          px_x_d = pad_x;
          px_y_d = pad_y;
          if (state_q == StPadFrame) set_long = ppu_px_valid;
          if (frame_last) begin
            done_d = 1'b1;
            case (state_q)
              StPadFrame: state_d = StVblank;
              StOffPad:   state_d = StOffFill;
              default:    state_d = lcd_en ? StVblank : StOff;
            endcase
          end
        end
        StOff: begin
          if (lcd_en) state_d = StVblank;
        end
        default: state_d = StVblank;
      endcase
    end
  end

  always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
    if (!GameBoy_reset_n) begin
      state_q     <= StVblank;
      px_x_q      <= 8'd0;
      px_y_q      <= 8'd0;
      ld_q        <= 2'b00;
      vld_q       <= 1'b0;
      done_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
      ld_q        <= ld_d;
      vld_q       <= vld_d;
      done_q      <= done_d;
      // A set in the same cycle as err_clr wins
      err_short_q <= set_short | (err_short_q & ~err_clr);
      err_long_q  <= set_long | (err_long_q & ~err_clr);
    end
  end

  assign LD         = ld_q;
  assign PX_VALID   = vld_q;
  assign px_x       = px_x_q;
  assign px_y       = px_y_q;
  assign frame_done = done_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;

endmodule

// File: tb/tb_gb_lcd_pixel_stream.sv
module tb_gb_lcd_pixel_stream;

  localparam int W = 160;
  localparam int H = 144;

`ifdef GB_LCD_STREAM_PALETTE_EN
  // idx 1: bgp 8'h1B -> 2'b10, obp1 8'hE4 -> 2'b01
  localparam logic [1:0] ExpBg   = 2'b10;
  localparam logic [1:0] ExpObp1 = 2'b01;
`else
  localparam logic [1:0] ExpBg   = 2'b01;
  localparam logic [1:0] ExpObp1 = 2'b01;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ppu_px, ppu_px_pal;
  logic       ppu_px_valid, ppu_line_end, ppu_frame_start, lcd_en, err_clr;
  logic [7:0] bgp, obp0, obp1;
  logic [1:0] LD;
  logic       PX_VALID, frame_done, err_short, err_long;
  logic [7:0] px_x, px_y;

  gb_lcd_pixel_stream #(.GB_W(W), .GB_H(H)) dut (
    .GameBoy_clk     (clk),
    .GameBoy_reset_n (rst_n),
    .ppu_px          (ppu_px),
    .ppu_px_pal      (ppu_px_pal),
    .ppu_px_valid    (ppu_px_valid),
    .ppu_line_end    (ppu_line_end),
    .ppu_frame_start (ppu_frame_start),
    .lcd_en          (lcd_en),
    .bgp             (bgp),
    .obp0            (obp0),
    .obp1            (obp1),
    .err_clr         (err_clr),
    .LD              (LD),
    .PX_VALID        (PX_VALID),
    .px_x            (px_x),
    .px_y            (px_y),
    .frame_done      (frame_done),
    .err_short       (err_short),
    .err_long        (err_long)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ld;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   nwrite = 0;
  int   mx = 0;  // raster position of the next expected write
  int   my = 0;

  // Scoreboard monitor: every write is checked against the next expected entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (PX_VALID) begin
        nwrite++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write #%0d: LD=%0d done=%0b, none expected",
                   nwrite, LD, frame_done);
        end else begin
          mon_e = q.pop_front();
          if (LD !== mon_e.ld || frame_done !== mon_e.done) begin
            errors++;
            $display("FAIL write #%0d: LD=%0d done=%0b, required LD=%0d done=%0b",
                     nwrite, LD, frame_done, mon_e.ld, mon_e.done);
          end
        end
      end else if (frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL stray_frame_done: frame_done=%0b without PX_VALID", frame_done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_w(input logic [1:0] ld);
    exp_t e;
    e.ld   = ld;
    e.done = (mx == W - 1) && (my == H - 1);
    q.push_back(e);
    if (mx == W - 1) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d writes outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic pulse_fs();
    ppu_frame_start = 1'b1;
    tick();
    ppu_frame_start = 1'b0;
  endtask

  task automatic send_px(input logic [1:0] idx, input logic [1:0] pal, input logic [1:0] ld);
    ppu_px = idx; ppu_px_pal = pal; ppu_px_valid = 1'b1;
    push_w(ld);
    tick();
    ppu_px_valid = 1'b0;
  endtask

  // Pixels first..n-1 of a line, idx cycling 0..3 on BG; pixels past W are dropped
  task automatic send_line(input int first, input int n, input bit le);
    for (int i = first; i < n; i++) begin
      ppu_px = 2'(i % 4); ppu_px_pal = 2'b00; ppu_px_valid = 1'b1;
      if (i < W) push_w(2'(i % 4));
      tick();
    end
    ppu_px_valid = 1'b0;
    if (le) begin
      ppu_line_end = 1'b1;
      tick();
      ppu_line_end = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; lcd_en = 1'b1; err_clr = 1'b0;
    ppu_px = 2'b00; ppu_px_pal = 2'b00; ppu_px_valid = 1'b0;
    ppu_line_end = 1'b0; ppu_frame_start = 1'b0;
    bgp = 8'hE4; obp0 = 8'hE4; obp1 = 8'hE4;
    repeat (3) tick();
    chk("reset_LD", 32'(LD), 0);
    chk("reset_PX_VALID", 32'(PX_VALID), 0);
    chk("reset_px_x", 32'(px_x), 0);
    chk("reset_px_y", 32'(px_y), 0);
    chk("reset_frame_done", 32'(frame_done), 0);
    chk("reset_err_short", 32'(err_short), 0);
    chk("reset_err_long", 32'(err_long), 0);
    rst_n = 1'b1;
    tick();

    // Nominal frame
    pulse_fs();
    for (int l = 0; l < H; l++) send_line(0, W, 1'b1);
    wait_drain(20, "nominal");
    chk("nominal_err_short", 32'(err_short), 0);
    chk("nominal_err_long", 32'(err_long), 0);
    chk("nominal_px_x", 32'(px_x), 0);
    chk("nominal_px_y", 32'(px_y), 0);

    // Palettes, short line, long line, early frame_start
    pulse_fs();
    bgp = 8'h1B; obp1 = 8'hE4;
    send_px(2'd1, 2'b00, ExpBg);
    send_px(2'd1, 2'b10, ExpObp1);
    send_px(2'd1, 2'b11, ExpBg);
    bgp = 8'hE4;
    send_line(3, W, 1'b1);
    for (int l = 1; l < 5; l++) send_line(0, W, 1'b1);
    send_line(0, 100, 1'b1);
    for (int i = 100; i < W; i++) push_w(2'b00);
    wait_drain(2 * W, "short_pad");
    chk("short_err_short", 32'(err_short), 1);
    chk("short_err_long", 32'(err_long), 0);
    chk("short_next_px_x", 32'(px_x), 0);
    chk("short_next_px_y", 32'(px_y), 6);
    send_line(0, W, 1'b1);
    send_line(0, W + 10, 1'b1);
    chk("long_err_long", 32'(err_long), 1);
    for (int l = 8; l < 50; l++) send_line(0, W, 1'b1);
    send_line(0, 20, 1'b0);
    pulse_fs();
    push_w(2'b00);
    while (!(mx == 0 && my == 0)) push_w(2'b00);
    wait_drain(W * H + 20, "early_frame");
    chk("early_px_x", 32'(px_x), 0);
    chk("early_px_y", 32'(px_y), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err_short", 32'(err_short), 0);
    chk("clr_err_long", 32'(err_long), 0);

    // LCD off at (20,10): rest of frame in zeros, then a full blank frame
    pulse_fs();
    for (int l = 0; l < 10; l++) send_line(0, W, 1'b1);
    send_line(0, 20, 1'b0);
    wait_drain(10, "pre_off");
    chk("off_px_x", 32'(px_x), 20);
    chk("off_px_y", 32'(px_y), 10);
    lcd_en = 1'b0;
    tick();
    push_w(2'b00);
    while (!(mx == 0 && my == 0)) push_w(2'b00);
    for (int i = 0; i < W * H; i++) push_w(2'b00);
    wait_drain(2 * W * H + 100, "lcd_off");
    repeat (10) tick();
    lcd_en = 1'b1;
    tick();
    tick();
    pulse_fs();
    send_line(0, W, 1'b1);
    send_line(0, W, 1'b1);
    send_line(0, 79, 1'b0);
    wait_drain(10, "resume");

    // Async reset while the 80th pixel of line 2 is being written
    ppu_px = 2'b11; ppu_px_pal = 2'b00; ppu_px_valid = 1'b1;
    tick();
    ppu_px_valid = 1'b0;
    chk("pre_reset_PX_VALID", 32'(PX_VALID), 1);
    chk("pre_reset_px_x", 32'(px_x), 80);
    rst_n = 1'b0;
    #1;
    chk("async_LD", 32'(LD), 0);
    chk("async_PX_VALID", 32'(PX_VALID), 0);
    chk("async_px_x", 32'(px_x), 0);
    chk("async_px_y", 32'(px_y), 2 - 2);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    mx = 0; my = 0;
    tick();
    // VBLANK after reset: a stray pixel is dropped and flagged
    ppu_px_valid = 1'b1;
    tick();
    ppu_px_valid = 1'b0;
    chk("vblank_drop_err_long", 32'(err_long), 1);
    chk("vblank_drop_px_x", 32'(px_x), 0);
    pulse_fs();
    send_line(0, W, 1'b1);
    send_line(0, W, 1'b1);
    wait_drain(10, "post_reset");
    chk("post_reset_px_x", 32'(px_x), 0);
    chk("post_reset_px_y", 32'(px_y), 2);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
